prco_mem_arbiter: RTL and testbench
===================================

// Module: prco_mem_arbiter
// PURPOSE
//  Shares the single-port block RAM of prco_core between the instruction-fetch unit and the load/store unit.
//  Uses a req/ack handshake per requester, 2-way round-robin on conflict, and a registered memory command.
//  Sits between the core datapath and the BRAM; counts contended cycles for debug (can be shown on LEDS).
// PARAMETERS
//  AW     16  word-address width
//  DW     16  data width
//  CNT_W  16  width of saturating conflict counter
// PORTS
//  clk50      in   1    system clock; all logic on rising edge
//  rst_n      in   1    synchronous reset, active-low
//  if_req     in   1    fetch request; held high until if_ack
//  if_addr    in   AW   fetch word address
//  if_ack     out  1    one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DW   read data; valid only while if_ack=1, else 0
//  ls_req     in   1    load/store request; held high until ls_ack
//  ls_we      in   1    1=store, 0=load
//  ls_addr    in   AW   load/store word address
//  ls_wdata   in   DW   store data
//  ls_ack     out  1    one-cycle pulse: access complete
//  ls_rdata   out  DW   load data; valid while ls_ack=1 and load, else 0
//  mem_en     out  1    BRAM enable (registered)
//  mem_we     out  1    BRAM write enable (registered)
//  mem_addr   out  AW   BRAM address (registered)
//  mem_wdata  out  DW   BRAM write data (registered)
//  mem_rdata  in   DW   BRAM read data; 1-cycle registered read latency
//  conflict_cnt out CNT_W  cycles where both requests were pending at an arbitration point; saturates
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, mem_en/mem_we=0, mem_addr/mem_wdata=0, acks=0,
//   conflict_cnt=0, last_owner=LS (fetch wins the first conflict). Reset mid-transaction aborts it with no ack.
//  FSM states: IDLE, ISSUE, RESP.
//   IDLE: if any req, pick owner, latch addr/we/wdata into mem_* with mem_en=1, go to ISSUE; else stay.
//   ISSUE: mem_en/mem_we drop to 0; go to RESP. mem_rdata is valid in RESP.
//   RESP: assert owner's ack (combinational from state+owner); rdata = mem_rdata for a load/fetch.
//    last_owner <= owner. If the other requester's req=1, arbitrate and issue it directly (RESP->ISSUE).
//    Otherwise go to IDLE. The acked requester's req is ignored in the RESP cycle.
//  Latency: req seen in IDLE -> ack 2 cycles later. Sustained back-to-back throughput: 1 access per 2 cycles.
//  Arbitration: only one req -> grant it. Both -> grant requester != last_owner, and conflict_cnt +1
//   (holds at all-ones).
//  Store: mem_we=1 only in the ISSUE-entry cycle; ls_ack in RESP; ls_rdata=0.
//  Exactly one ack may be high in any cycle; never ack without a prior grant.
//  mem_* outputs are captured at grant; requester input changes after grant do not affect the access.
//  req dropped before ack (protocol violation): the access still completes and the ack is still issued.
// STRUCTURE
//  prco_defs.vh (shared include): owner encodings OWN_IF/OWN_LS, FSM state encodings.
//  Sub-module prco_rr_pick: 2-way round-robin picker (req_a, req_b, last -> grant, conflict).
//   Purely combinational; last_owner register lives in the arbiter.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> all outputs 0, conflict_cnt=0.
//  2 Single fetch: if_req, if_addr=0x0010, BRAM[0x10]=0xBEEF.
//    -> mem_en=1 with addr 0x0010 next cycle; if_ack=1 with if_rdata=0xBEEF 2 cycles after req.
//  3 Store then load: ls_we=1, addr=0x0020, wdata=0x1234, then a load from 0x0020.
//    -> second ls_ack has ls_rdata=0x1234; first ls_ack has ls_rdata=0.
//  4 Conflict after reset: if_req and ls_req both high together.
//    -> fetch acked first, LS acked 2 cycles later (RESP->ISSUE); conflict_cnt=1.
//  5 Both held continuously for 20 cycles.
//    -> acks alternate IF,LS,IF,...; never both high in one cycle; one ack every 2 cycles.
//  6 Reset in ISSUE of a load -> no ack; IDLE next; new req served normally.
//    Saturation: force CNT_W=4 with 20 conflicts -> conflict_cnt=15.

Source files
------------

// File: rtl/prco_mem_arbiter_pkg.sv
// Shared types for the prco BRAM arbiter: FSM state and requester (owner) encodings.
package prco_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    owner_t r;
    if (o == OWN_IF) r = OWN_LS;
    else             r = OWN_IF;
    return r;
  endfunction

endpackage

// File: rtl/prco_rr_pick.sv
// Two-way round-robin picker: a lone request wins, on a tie the requester that did not go last wins.
module prco_rr_pick
  import prco_mem_arbiter_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_t last,
  output owner_t grant,
  output logic   any,
  output logic   conflict
);

  always_comb begin
    grant    = OWN_IF;
    any      = req_a | req_b;
    conflict = req_a & req_b;
    if (conflict) begin
      grant = other_owner(last);
    end else if (req_b) begin
      grant = OWN_LS;
    end
  end

endmodule

// File: rtl/prco_mem_arbiter.sv
// Arbitrates the single-port prco_core BRAM between instruction fetch and load/store,
// with a registered memory command and a saturating contention counter.
module prco_mem_arbiter
  import prco_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_ack,
  output logic [DW-1:0]    if_rdata,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [AW-1:0]    ls_addr,
  input  logic [DW-1:0]    ls_wdata,
  output logic             ls_ack,
  output logic [DW-1:0]    ls_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  state_t state, state_nxt;
  owner_t owner, last_owner, grant;
  logic   pick_if, pick_ls, any, conflict, issue, op_store;

  // The requester being acked this cycle is already served and must not be re-granted.
  always_comb begin
    pick_if = if_req & ~((state == ST_RESP) && (owner == OWN_IF));
    pick_ls = ls_req & ~((state == ST_RESP) && (owner == OWN_LS));
    issue   = any & ((state == ST_IDLE) || (state == ST_RESP));
  end

  prco_rr_pick u_pick (
    .req_a    (pick_if),
    .req_b    (pick_ls),
    .last     (last_owner),
    .grant    (grant),
    .any      (any),
    .conflict (conflict)
  );

  always_ff @(posedge clk50) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = any ? ST_ISSUE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Acks and read data come straight from the response state; mem_rdata is valid then.
  always_comb begin
    if_ack   = 1'b0;
    ls_ack   = 1'b0;
    if_rdata = '0;
    ls_rdata = '0;
    if (state == ST_RESP) begin
      if (owner == OWN_IF) begin
        if_ack   = 1'b1;
        if_rdata = mem_rdata;
      end else begin
        ls_ack = 1'b1;
        if (!op_store) ls_rdata = mem_rdata;
      end
    end
  end

  // Command is captured at grant so later requester changes cannot disturb the access.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      owner        <= OWN_IF;
      last_owner   <= OWN_LS;
      op_store     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      mem_en <= issue;
      mem_we <= issue & (grant == OWN_LS) & ls_we;
      if (issue) begin
        owner    <= grant;
        op_store <= (grant == OWN_LS) & ls_we;
        if (grant == OWN_IF) begin
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end else begin
          mem_addr  <= ls_addr;
          mem_wdata <= ls_wdata;
        end
      end
      if (state == ST_RESP) last_owner <= owner;
      if (issue && conflict && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prco_mem_arbiter.sv
// Directed bench for prco_mem_arbiter: timestamp-based transaction model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_prco_mem_arbiter;

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [15:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic        if_ack, ls_ack, mem_en, mem_we;
  logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata, conflict_cnt;
  logic [15:0] mem_rdata = '0;
  logic        if_ack_4, ls_ack_4, mem_en_4, mem_we_4;
  logic [15:0] if_rdata_4, ls_rdata_4, mem_addr_4, mem_wdata_4;
  logic [3:0]  cnt_4;

  int cmp = 0;
  int mism = 0;
  int cyc = 0;

  always #5 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  prco_mem_arbiter #(.AW(16), .DW(16), .CNT_W(16)) dut (
    .clk50(clk50), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter copy sharing the same inputs, used to see saturation.
  prco_mem_arbiter #(.AW(16), .DW(16), .CNT_W(4)) dut4 (
    .clk50(clk50), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_4), .if_rdata(if_rdata_4),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack_4), .ls_rdata(ls_rdata_4),
    .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4),
    .mem_rdata(mem_rdata), .conflict_cnt(cnt_4)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return (16'(a) * 16'h0101) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp = cmp + 1;
    if (act !== exp) begin
      mism = mism + 1;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // BRAM with one-cycle registered read.
  logic [15:0] bram [256];
  always @(posedge clk50) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_val(8'(i));
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= bram[mem_addr[7:0]];
    end
  end

  // Model: a grant at cycle t puts the command on mem_* at t+1 and the ack at t+2.
  logic [15:0] mm [256];
  bit          started = 0, busy = 0, m_we = 0, m_own = 0, m_last = 1;
  int          t = 0, en_t = -1, ack_t = -1, cnt16 = 0, cnt4 = 0;
  logic [15:0] m_addr = '0, m_wdata = '0;

  always @(negedge clk50) begin
    bit e_if, e_ls, resp, c_if, c_ls, g;
    if (preload) for (int i = 0; i < 256; i++) mm[i] = init_val(8'(i));
    if (started) begin
      e_if = busy && (ack_t == t) && !m_own;
      e_ls = busy && (ack_t == t) && m_own;
      chk("if_ack", 32'(if_ack), 32'(e_if));
      chk("ls_ack", 32'(ls_ack), 32'(e_ls));
      chk("one_ack", 32'(if_ack & ls_ack), 32'(0));
      chk("if_rdata", 32'(if_rdata), e_if ? 32'(mm[m_addr[7:0]]) : 32'(0));
      chk("ls_rdata", 32'(ls_rdata), (e_ls && !m_we) ? 32'(mm[m_addr[7:0]]) : 32'(0));
      chk("mem_en", 32'(mem_en), 32'(busy && (en_t == t)));
      chk("mem_we", 32'(mem_we), 32'(busy && (en_t == t) && m_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt16));
      chk("cnt_4", 32'(cnt_4), 32'(cnt4));
    end
    if (!rst_n) begin
      busy = 0; m_addr = '0; m_wdata = '0; m_last = 1; m_we = 0;
      cnt16 = 0; cnt4 = 0; en_t = -1; ack_t = -1; started = 1;
    end else if (started) begin
      resp = busy && (ack_t == t);
      if (resp) begin
        m_last = m_own;
        if (m_we) mm[m_addr[7:0]] = m_wdata;
        busy = 0;
      end
      if (!busy) begin
        c_if = if_req && !(resp && !m_own);
        c_ls = ls_req && !(resp && m_own);
        g = c_ls;
        if (c_if && c_ls) begin
          g = !m_last;
          if (cnt16 < 65535) cnt16++;
          if (cnt4 < 15) cnt4++;
        end
        if (c_if || c_ls) begin
          busy = 1; m_own = g; en_t = t + 1; ack_t = t + 2;
          m_we    = g && ls_we;
          m_addr  = g ? ls_addr : if_addr;
          m_wdata = g ? ls_wdata : 16'h0;
        end
      end
    end
    t++;
  end

  task automatic tick();
    @(posedge clk50); #1;
  endtask

  task automatic do_if(input logic [15:0] a, output logic [15:0] rd, output int at);
    bit done = 0;
    int n = 0;
    rd = '0; at = -1;
    if_req = 1'b1; if_addr = a;
    while (!done && n < 40) begin
      @(negedge clk50);
      if (if_ack) begin done = 1; rd = if_rdata; at = cyc; end
      n++;
    end
    chk("if_wait", 32'(done), 32'(1));
    tick();
    if_req = 1'b0;
  endtask

  task automatic do_ls(input logic we, input logic [15:0] a, input logic [15:0] wd,
                       output logic [15:0] rd, output int at);
    bit done = 0;
    int n = 0;
    rd = '0; at = -1;
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
    while (!done && n < 40) begin
      @(negedge clk50);
      if (ls_ack) begin done = 1; rd = ls_rdata; at = cyc; end
      n++;
    end
    chk("ls_wait", 32'(done), 32'(1));
    tick();
    ls_req = 1'b0;
  endtask

  initial begin
    logic [15:0] r1, r2;
    int a1, a2, n_if, n_ls;
    // Reset held three cycles
    repeat (3) tick();
    chk("rst_if_ack", 32'(if_ack), 32'(0));
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    chk("rst_cnt", 32'(conflict_cnt), 32'(0));
    rst_n = 1'b1; preload = 1'b0;
    tick();

    // Single fetch: command next cycle, ack two cycles after the request
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk50);
    @(negedge clk50);
    chk("fetch_en", 32'(mem_en), 32'(1));
    chk("fetch_addr", 32'(mem_addr), 32'h0010);
    @(negedge clk50);
    chk("fetch_ack", 32'(if_ack), 32'(1));
    chk("fetch_data", 32'(if_rdata), 32'hBEEF);
    tick();
    if_req = 1'b0;
    tick();

    // Store then load back
    do_ls(1'b1, 16'h0020, 16'h1234, r1, a1);
    chk("store_rdata", 32'(r1), 32'h0);
    do_ls(1'b0, 16'h0020, 16'h0000, r2, a2);
    chk("load_rdata", 32'(r2), 32'h1234);
    tick();

    // First conflict: fetch wins, load follows two cycles later
    fork
      do_if(16'h0030, r1, a1);
      do_ls(1'b0, 16'h0021, 16'h0, r2, a2);
    join
    chk("conf_order", 32'(a2 - a1), 32'd2);
    chk("conf_if_data", 32'(r1), 32'h6A6A);
    chk("conf_ls_data", 32'(r2), 32'h7B7B);
    chk("conf_cnt1", 32'(conflict_cnt), 32'd1);
    tick();

    // Both held for 20 cycles: IF,LS,IF,... one ack every other cycle
    n_if = 0; n_ls = 0;
    if_req = 1'b1; if_addr = 16'h0041;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0040;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50);
      if (if_ack) n_if++;
      if (ls_ack) n_ls++;
    end
    tick();
    if_req = 1'b0; ls_req = 1'b0;
    chk("hold_if_acks", 32'(n_if), 32'd5);
    chk("hold_ls_acks", 32'(n_ls), 32'd4);
    repeat (4) tick();
    chk("hold_cnt", 32'(conflict_cnt), 32'd2);

    // Reset during ISSUE of a load aborts it without an ack
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0022;
    tick();
    rst_n = 1'b0; ls_req = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk50);
    chk("abort_noack", 32'(ls_ack), 32'(0));
    chk("abort_cnt", 32'(conflict_cnt), 32'(0));
    tick();
    do_ls(1'b0, 16'h0022, 16'h0, r1, a1);
    chk("after_abort", 32'(r1), 32'h7878);

    // 20 conflicts: the 4-bit counter pins at 15
    for (int k = 0; k < 20; k++) begin
      fork
        do_if(16'(16'h0050 + k), r1, a1);
        do_ls(1'b0, 16'(16'h0080 + k), 16'h0, r2, a2);
      join
    end
    tick();
    chk("sat_cnt4", 32'(cnt_4), 32'd15);
    chk("sat_cnt16", 32'(conflict_cnt), 32'd20);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
